// File: rtl/blowfish128_pkg.sv
// rtl/blowfish128_pkg.sv - Blowfish-128 key schedule constants, P-array init words and FSM states
package blowfish128_pkg;

    localparam int NUM_SUBKEYS   = 20;
    localparam int MAX_KEY_WORDS = 16;

    localparam logic [31:0] PINIT [NUM_SUBKEYS] = '{
        32'h243F6A88, 32'h85A308D3, 32'h13198A2E, 32'h03707344, 32'hA4093822,
        32'h299F31D0, 32'h082EFA98, 32'hEC4E6C89, 32'h452821E6, 32'h38D01377,
        32'hBE5466CF, 32'h34E90C6C, 32'hC0AC29B7, 32'hC97C50DD, 32'h3F84D5B5,
        32'hB5470917, 32'h9216D5D9, 32'h8979FB1B, 32'hD1310BA6, 32'h98DFB5AC
    };

    typedef enum logic [1:0] {IDLE, GEN, DONE} state_t;

    // Number of 32-bit key words in the cycle, with key_length clamped to 1..8.
    function automatic logic [4:0] key_word_count(input logic [3:0] key_length);
        if (key_length == 4'd0) return 5'd2;
        if (key_length > 4'd8)  return 5'd16;
        return {key_length, 1'b0};
    endfunction

endpackage

// File: rtl/blowfish128_pinit_rom.sv
// rtl/blowfish128_pinit_rom.sv - combinational lookup of the pi-derived P-array initial words
module blowfish128_pinit_rom
    import blowfish128_pkg::*;
(
    input  logic [4:0]  idx,
    output logic [31:0] word
);

    always_comb begin
        word = '0;
        if (idx < 5'(NUM_SUBKEYS)) word = PINIT[idx];
    end

endmodule

// File: rtl/blowfish128_subkey_gen.sv
// rtl/blowfish128_subkey_gen.sv - Blowfish-128 P1..P20 subkey generator, one subkey per clock
// Optional macro BF_DEC_REVERSE_EN: latched Encrypt selects encrypt or reversed (decrypt) output order.
module blowfish128_subkey_gen
    import blowfish128_pkg::*;
(
    input  logic        Clk,
    input  logic        RstN,
    input  logic [63:0] key0,
    input  logic [63:0] key1,
    input  logic [63:0] key2,
    input  logic [63:0] key3,
    input  logic [63:0] key4,
    input  logic [63:0] key5,
    input  logic [63:0] key6,
    input  logic [63:0] key7,
    input  logic [3:0]  key_length,
    input  logic        Encrypt,
    input  logic        Enable,
    output logic        skey_ready,
    output logic [31:0] P1,  P2,  P3,  P4,  P5,  P6,  P7,  P8,  P9,  P10,
    output logic [31:0] P11, P12, P13, P14, P15, P16, P17, P18, P19, P20
);

    state_t      state, state_nx;
    logic [4:0]  cnt;
    logic [3:0]  widx;
    logic [4:0]  nwords;
    logic [31:0] kw [MAX_KEY_WORDS];
    logic [31:0] r  [NUM_SUBKEYS];
    logic [31:0] p  [NUM_SUBKEYS];
    logic [63:0] key_in [8];
    logic [31:0] pinit_word;
    logic        enc;

    assign key_in = '{key0, key1, key2, key3, key4, key5, key6, key7};

    blowfish128_pinit_rom u_rom (
        .idx  (cnt),
        .word (pinit_word)
    );

    always_ff @(posedge Clk) begin
        if (RstN) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (Enable) state_nx = GEN;
            GEN: begin
                if (!Enable)                             state_nx = IDLE;
                else if (cnt == 5'(NUM_SUBKEYS - 1))     state_nx = DONE;
            end
            DONE: if (!Enable) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Key words wrap via their own counter so no modulo/divider is needed.
    always_ff @(posedge Clk) begin
        if (RstN) begin
            cnt    <= '0;
            widx   <= '0;
            nwords <= '0;
            for (int i = 0; i < MAX_KEY_WORDS; i++) kw[i] <= '0;
            for (int i = 0; i < NUM_SUBKEYS; i++)   r[i]  <= '0;
        end else if (Enable) begin
            if (state == IDLE) begin
                cnt    <= '0;
                widx   <= '0;
                nwords <= key_word_count(key_length);
                for (int j = 0; j < 8; j++) begin
                    kw[2*j]   <= key_in[j][63:32];
                    kw[2*j+1] <= key_in[j][31:0];
                end
            end else if (state == GEN) begin
                r[cnt] <= pinit_word ^ kw[widx];
                cnt    <= cnt + 5'd1;
                widx   <= ({1'b0, widx} == nwords - 5'd1) ? 4'd0 : widx + 4'd1;
            end
        end
    end

`ifdef BF_DEC_REVERSE_EN
    always_ff @(posedge Clk) begin
        if (RstN)                            enc <= 1'b0;
        else if (Enable && state == IDLE)    enc <= Encrypt;
    end
`else
    logic enc_unused;
    assign enc_unused = Encrypt;
    assign enc        = 1'b1;
`endif

    assign skey_ready = (state == DONE);

    for (genvar i = 0; i < NUM_SUBKEYS; i++) begin : g_out
        assign p[i] = enc ? r[i] : r[NUM_SUBKEYS-1-i];
    end

    assign P1  = p[0];   assign P2  = p[1];   assign P3  = p[2];   assign P4  = p[3];
    assign P5  = p[4];   assign P6  = p[5];   assign P7  = p[6];   assign P8  = p[7];
    assign P9  = p[8];   assign P10 = p[9];   assign P11 = p[10];  assign P12 = p[11];
    assign P13 = p[12];  assign P14 = p[13];  assign P15 = p[14];  assign P16 = p[15];
    assign P17 = p[16];  assign P18 = p[17];  assign P19 = p[18];  assign P20 = p[19];

endmodule

// File: tb/tb_blowfish128_subkey_gen.sv
// tb/tb_blowfish128_subkey_gen.sv - self-checking bench for blowfish128_subkey_gen (honours BF_DEC_REVERSE_EN)
module tb_blowfish128_subkey_gen;

    logic        Clk = 1'b0;
    logic        RstN;
    logic [63:0] key [8];
    logic [3:0]  key_length;
    logic        Encrypt;
    logic        Enable;
    logic        skey_ready;
    logic [31:0] P [20];

    int total = 0;
    int bad   = 0;

    logic [31:0] m_w [16];
    int          m_n;
    logic        m_enc;

    logic [31:0] pi_tab [20] = '{
        32'h243F6A88, 32'h85A308D3, 32'h13198A2E, 32'h03707344, 32'hA4093822,
        32'h299F31D0, 32'h082EFA98, 32'hEC4E6C89, 32'h452821E6, 32'h38D01377,
        32'hBE5466CF, 32'h34E90C6C, 32'hC0AC29B7, 32'hC97C50DD, 32'h3F84D5B5,
        32'hB5470917, 32'h9216D5D9, 32'h8979FB1B, 32'hD1310BA6, 32'h98DFB5AC
    };

    always #5 Clk = ~Clk;

    blowfish128_subkey_gen dut (
        .Clk(Clk), .RstN(RstN),
        .key0(key[0]), .key1(key[1]), .key2(key[2]), .key3(key[3]),
        .key4(key[4]), .key5(key[5]), .key6(key[6]), .key7(key[7]),
        .key_length(key_length), .Encrypt(Encrypt), .Enable(Enable),
        .skey_ready(skey_ready),
        .P1(P[0]),   .P2(P[1]),   .P3(P[2]),   .P4(P[3]),   .P5(P[4]),
        .P6(P[5]),   .P7(P[6]),   .P8(P[7]),   .P9(P[8]),   .P10(P[9]),
        .P11(P[10]), .P12(P[11]), .P13(P[12]), .P14(P[13]), .P15(P[14]),
        .P16(P[15]), .P17(P[16]), .P18(P[17]), .P19(P[18]), .P20(P[19])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // Subkey i (0-based output position) from the key words captured at start.
    function automatic logic [31:0] exp_p(input int i);
        int idx;
        idx = m_enc ? i : 19 - i;
        return pi_tab[idx] ^ m_w[idx % m_n];
    endfunction

    task automatic start(input logic [3:0] kl, input logic en);
        key_length = kl;
        Encrypt    = en;
        Enable     = 1'b1;
        for (int j = 0; j < 8; j++) begin
            m_w[2*j]   = key[j][63:32];
            m_w[2*j+1] = key[j][31:0];
        end
        m_n = (kl == 0) ? 2 : (kl > 8) ? 16 : 2 * kl;
`ifdef BF_DEC_REVERSE_EN
        m_enc = en;
`else
        m_enc = 1'b1;
`endif
        step();
        for (int j = 0; j < 8; j++) key[j] = {$urandom, $urandom};
        key_length = 4'($urandom);
        Encrypt    = 1'($urandom);
    endtask

    task automatic run_full(input string tag, input logic [3:0] kl, input logic en);
        start(kl, en);
        for (int e = 1; e <= 20; e++) begin
            step();
            if (e >= 19) check($sformatf("%s_ready_e%0d", tag, e), 32'(skey_ready), (e == 20) ? 32'd1 : 32'd0);
        end
        for (int i = 0; i < 20; i++) check($sformatf("%s_P%0d", tag, i + 1), P[i], exp_p(i));
        step();
        check($sformatf("%s_ready_hold", tag), 32'(skey_ready), 32'd1);
    endtask

    task automatic stop();
        Enable = 1'b0;
        step();
        check("ready_clear", 32'(skey_ready), 32'd0);
    endtask

    task automatic set_ref_key(input logic [63:0] k0, input logic [63:0] k1);
        for (int j = 0; j < 8; j++) key[j] = '0;
        key[0] = k0;
        key[1] = k1;
    endtask

    initial begin
        RstN = 1'b1; Enable = 1'b0; Encrypt = 1'b1; key_length = 4'd0;
        for (int j = 0; j < 8; j++) key[j] = '0;
        repeat (5) step();
        RstN = 1'b0;
        check("reset_ready", 32'(skey_ready), 32'd0);
        for (int i = 0; i < 20; i++) check($sformatf("reset_P%0d", i + 1), P[i], 32'h0);
        step();

        set_ref_key(64'h0123456789ABCDEF, 64'hFEDCBA9876543210);
        run_full("enc", 4'd4, 1'b1);
        check("enc_P1_lit", P[0], 32'h251C2FEF);
        check("enc_P2_lit", P[1], 32'h0C08C53C);
        check("enc_P9_lit", P[8], 32'h440B6481);
        stop();

        set_ref_key(64'h0123456789ABCDEF, 64'hFEDCBA9876543210);
        run_full("dec", 4'd4, 1'b0);
`ifdef BF_DEC_REVERSE_EN
        check("dec_P1_lit", P[0], 32'hEE8B87BC);
        check("dec_P20_lit", P[19], 32'h251C2FEF);
`else
        check("dec_P1_lit", P[0], 32'h251C2FEF);
`endif
        stop();

        set_ref_key(64'h0123456789ABCDEF, 64'hFEDCBA9876543210);
        run_full("kl1", 4'd1, 1'b1);
        check("kl1_P3_lit", P[2], 32'h123ACF49);
        stop();

        set_ref_key(64'h0123456789ABCDEF, 64'hFEDCBA9876543210);
        run_full("kl0", 4'd0, 1'b1);
        check("kl0_P3_lit", P[2], 32'h123ACF49);
        stop();

        for (int j = 0; j < 8; j++) key[j] = {$urandom, $urandom};
        run_full("kl15", 4'd15, 1'b1);
        stop();

        // Abort at GEN cycle 10, then a clean rerun.
        for (int j = 0; j < 8; j++) key[j] = {$urandom, $urandom};
        start(4'd5, 1'b1);
        repeat (10) step();
        Enable = 1'b0;
        for (int e = 0; e < 4; e++) begin
            step();
            check($sformatf("abort_ready_%0d", e), 32'(skey_ready), 32'd0);
        end
        for (int j = 0; j < 8; j++) key[j] = {$urandom, $urandom};
        run_full("rerun", 4'd6, 1'b0);
        stop();

        // Reset mid-generation has priority over Enable.
        for (int j = 0; j < 8; j++) key[j] = {$urandom, $urandom};
        start(4'd8, 1'b1);
        repeat (7) step();
        RstN = 1'b1;
        step();
        RstN = 1'b0;
        Enable = 1'b0;
        check("midrst_ready", 32'(skey_ready), 32'd0);
        for (int i = 0; i < 20; i++) check($sformatf("midrst_P%0d", i + 1), P[i], 32'h0);
        step();

        for (int t = 0; t < 8; t++) begin
            for (int j = 0; j < 8; j++) key[j] = {$urandom, $urandom};
            run_full($sformatf("rnd%0d", t), 4'($urandom_range(0, 15)), 1'($urandom));
            stop();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
